// File: rtl/tt_bounce_sprite_engine.sv
// tt_bounce_sprite_engine: per-frame bounce motion of N square sprites plus a registered per-pixel topmost-sprite hit test
module tt_bounce_sprite_engine #(
    parameter int N_SPRITES       = 4,
    parameter int SPRITE_SIZE     = 128,
    parameter int DISPLAY_WIDTH   = 640,
    parameter int DISPLAY_HEIGHT  = 480,
    parameter int STEP_W          = 3,
    localparam int ID_W           = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1,
    localparam int REL_W          = $clog2(SPRITE_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              frame_tick,
    input  logic              pause,
    input  logic [STEP_W-1:0] speed,
    output logic              hit,
    output logic [ID_W-1:0]   hit_id,
    output logic [REL_W-1:0]  rel_x,
    output logic [REL_W-1:0]  rel_y,
    output logic [2:0]        color_idx,
    output logic              corner_pulse,
    output logic              busy
);
    localparam logic [10:0] MAX_X = 11'(DISPLAY_WIDTH - SPRITE_SIZE);
    localparam logic [10:0] MAX_Y = 11'(DISPLAY_HEIGHT - SPRITE_SIZE);

    if (N_SPRITES < 1 || N_SPRITES > 8 || SPRITE_SIZE < 16 || SPRITE_SIZE > 128 ||
        (SPRITE_SIZE & (SPRITE_SIZE - 1)) != 0 ||
        16 + 64 * (N_SPRITES - 1) > DISPLAY_WIDTH - SPRITE_SIZE ||
        16 + 32 * (N_SPRITES - 1) > DISPLAY_HEIGHT - SPRITE_SIZE) begin : g_bad_params
        $error("tt_bounce_sprite_engine: parameters out of range or reset layout off-screen");
    end

    typedef enum logic {IDLE, UPD} state_t;
    typedef struct packed {
        logic        b;
        logic        d;
        logic [10:0] p;
    } axis_t;

    // One axis step: move toward the current wall, clamp and reverse when the step would reach it
    function automatic axis_t move(input logic [10:0] p, input logic d, input logic [10:0] s,
                                   input logic [10:0] lim);
        logic [10:0] sum;
        sum = p + s;
        return s == '0 ? {1'b0, d, p} :
               d ? (sum >= lim ? {1'b1, 1'b0, lim} : {1'b0, 1'b1, sum}) :
                   (p <= s ? {1'b1, 1'b1, 11'd0} : {1'b0, 1'b0, p - s});
    endfunction

    state_t              state;
    logic [ID_W-1:0]     idx;
    logic [STEP_W-1:0]   step_r;
    logic [10:0]         left [N_SPRITES];
    logic [10:0]         top  [N_SPRITES];
    logic [2:0]          col  [N_SPRITES];
    logic [N_SPRITES-1:0] dir_x, dir_y;
    axis_t               ax, ay;

    assign ax   = move(left[idx], dir_x[idx], 11'(step_r), MAX_X);
    assign ay   = move(top[idx], dir_y[idx], 11'(step_r), MAX_Y);
    assign busy = state == UPD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            step_r       <= '0;
            corner_pulse <= 1'b0;
            for (int i = 0; i < N_SPRITES; i++) begin
                left[i]  <= 11'(16 + 64 * i);
                top[i]   <= 11'(16 + 32 * i);
                dir_x[i] <= i % 2 == 0;
                dir_y[i] <= (i / 2) % 2 == 1;
                col[i]   <= 3'(i);
            end
        end else begin
            corner_pulse <= 1'b0;
            if (state == IDLE) begin
                if (frame_tick && !pause) begin
                    state  <= UPD;
                    idx    <= '0;
                    step_r <= speed;
                end
            end else begin
                left[idx]    <= ax.p;
                dir_x[idx]   <= ax.d;
                top[idx]     <= ay.p;
                dir_y[idx]   <= ay.d;
                col[idx]     <= col[idx] + {2'b00, ax.b | ay.b};
                corner_pulse <= ax.b & ay.b;
                idx          <= idx + 1'b1;
                if (idx == ID_W'(N_SPRITES - 1))
                    state <= IDLE;
            end
        end
    end

    // Unsigned 11-bit offsets: pixels left of / above a sprite wrap to large values and miss
    logic [10:0]          dx [N_SPRITES];
    logic [10:0]          dy [N_SPRITES];
    logic [N_SPRITES-1:0] cov;

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_cov
        assign dx[g]  = {1'b0, pix_x} - left[g];
        assign dy[g]  = {1'b0, pix_y} - top[g];
        assign cov[g] = dx[g] < 11'(SPRITE_SIZE) && dy[g] < 11'(SPRITE_SIZE);
    end

    logic             hit_c;
    logic [ID_W-1:0]  id_c;
    logic [REL_W-1:0] rx_c, ry_c;
    logic [2:0]       col_c;

    // Walk from the highest index down so the lowest covering index is written last and wins
    always_comb begin
        hit_c = 1'b0;
        id_c  = '0;
        rx_c  = '0;
        ry_c  = '0;
        col_c = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (cov[i]) begin
                hit_c = 1'b1;
                id_c  = ID_W'(i);
                rx_c  = dx[i][REL_W-1:0];
                ry_c  = dy[i][REL_W-1:0];
                col_c = col[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit       <= 1'b0;
            hit_id    <= '0;
            rel_x     <= '0;
            rel_y     <= '0;
            color_idx <= '0;
        end else begin
            hit       <= hit_c;
            hit_id    <= id_c;
            rel_x     <= rx_c;
            rel_y     <= ry_c;
            color_idx <= col_c;
        end
    end
endmodule

// File: tb/tb_tt_bounce_sprite_engine.sv
// tb_tt_bounce_sprite_engine: frame-level model of motion and hit test, compared every cycle, plus literal pins
module tb_tt_bounce_sprite_engine;
    localparam int N  = 4;
    localparam int SZ = 128;
    localparam int MX = 512;
    localparam int MY = 352;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pause = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [2:0] speed = '0;
    logic       hit, corner_pulse, busy;
    logic [1:0] hit_id;
    logic [6:0] rel_x, rel_y;
    logic [2:0] color_idx;

    always #5 clk = ~clk;

    tt_bounce_sprite_engine dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .frame_tick(frame_tick), .pause(pause), .speed(speed),
        .hit(hit), .hit_id(hit_id), .rel_x(rel_x), .rel_y(rel_y),
        .color_idx(color_idx), .corner_pulse(corner_pulse), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int corner_cnt = 0;
    int sw = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: whole frames are computed at once, committed when the DUT's last sprite update lands
    int  m_l[N], m_t[N], m_c[N], n_l[N], n_t[N], n_c[N];
    bit  m_dx[N], m_dy[N], n_dx[N], n_dy[N], cf[N];
    int  ph = 0;
    bit  mvalid = 0, chk_hit = 0, e_hit, e_corner, e_busy, bx, by;
    int  e_id, e_rx, e_ry, e_col;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_l[i]  = 16 + 64 * i;
            m_t[i]  = 16 + 32 * i;
            m_dx[i] = (i % 2) == 0;
            m_dy[i] = ((i / 2) % 2) == 1;
            m_c[i]  = i % 8;
        end
    endtask

    task automatic axis(inout int p, inout bit d, input int s, input int lim, output bit b);
        b = 0;
        if (s == 0) return;
        if (d) begin
            if (p + s >= lim) begin p = lim; d = 0; b = 1; end
            else p = p + s;
        end else begin
            if (p <= s) begin p = 0; d = 1; b = 1; end
            else p = p - s;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            ph = 0;
            {e_hit, e_corner, e_busy} = '0;
            {e_id, e_rx, e_ry, e_col} = '0;
            chk_hit = 1;
        end else begin
            chk_hit = ph == 0;
            e_hit = 0; e_id = 0; e_rx = 0; e_ry = 0; e_col = 0;
            for (int i = N - 1; i >= 0; i--) begin
                int ox, oy;
                ox = int'(pix_x) - m_l[i];
                oy = int'(pix_y) - m_t[i];
                if (ox >= 0 && ox < SZ && oy >= 0 && oy < SZ) begin
                    e_hit = 1; e_id = i; e_rx = ox; e_ry = oy; e_col = m_c[i];
                end
            end
            e_corner = 0;
            if (ph == 0) begin
                if (frame_tick && !pause) begin
                    for (int i = 0; i < N; i++) begin
                        n_l[i] = m_l[i]; n_dx[i] = m_dx[i];
                        n_t[i] = m_t[i]; n_dy[i] = m_dy[i];
                        axis(n_l[i], n_dx[i], int'(speed), MX, bx);
                        axis(n_t[i], n_dy[i], int'(speed), MY, by);
                        n_c[i] = (m_c[i] + ((bx || by) ? 1 : 0)) % 8;
                        cf[i]  = bx && by;
                    end
                    ph = 1;
                end
            end else begin
                e_corner = cf[ph-1];
                if (ph == N) begin
                    m_l = n_l; m_t = n_t; m_c = n_c; m_dx = n_dx; m_dy = n_dy;
                    ph = 0;
                end else ph++;
            end
            e_busy = ph != 0;
        end
        mvalid = 1;
    end

    initial forever begin
        @(negedge clk);
        if (busy) busy_cnt++;
        if (corner_pulse) corner_cnt++;
        if (mvalid) begin
            chk("busy", int'(busy), int'(e_busy));
            chk("corner_pulse", int'(corner_pulse), int'(e_corner));
            if (chk_hit) begin
                chk("hit", int'(hit), int'(e_hit));
                chk("hit_id", int'(hit_id), e_id);
                chk("rel_x", int'(rel_x), e_rx);
                chk("rel_y", int'(rel_y), e_ry);
                chk("color_idx", int'(color_idx), e_col);
            end
        end
    end

    task automatic next_pix();
        sw++;
        pix_x = 10'((sw * 37) % 640);
        pix_y = 10'((sw * 23) % 480);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); next_pix(); end
    endtask

    task automatic frame(input int s, input bit hold = 0);
        @(negedge clk);
        speed = 3'(s);
        frame_tick = 1'b1;
        next_pix();
        if (hold) idle(1);
        @(negedge clk);
        frame_tick = 1'b0;
        next_pix();
        idle(N + 2);
    endtask

    // Packed {hit, hit_id, rel_x, rel_y, color_idx} one cycle after driving (x,y)
    task automatic probe(input string nm, input int x, input int y,
                         input int eh, input int eid, input int erx, input int ery, input int ecol);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(negedge clk);
        chk(nm, int'({hit, hit_id, rel_x, rel_y, color_idx}),
            (eh << 19) | (eid << 17) | (erx << 10) | (ery << 3) | ecol);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle(3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_hit", int'(hit), 0);
        @(negedge clk);
        rst_n = 1'b1;

        probe("t1_s0_origin", 16, 16, 1, 0, 0, 0, 0);
        probe("t1_left_miss", 15, 16, 0, 0, 0, 0, 0);
        probe("t1_overlap", 100, 100, 1, 0, 84, 84, 0);
        probe("t1_s0_far", 143, 143, 1, 0, 127, 127, 0);
        probe("t1_edge_miss", 144, 16, 0, 0, 0, 0, 0);
        probe("t1_s3", 300, 200, 1, 3, 92, 88, 3);

        frame(1);
        chk("t2_busy_cycles", busy_cnt, 4);
        probe("t2_s0", 17, 15, 1, 0, 0, 0, 0);
        probe("t2_s0_moved", 16, 15, 0, 0, 0, 0, 0);
        probe("t2_s1", 79, 143, 1, 1, 0, 96, 1);

        pause = 1'b1;
        frame(1);
        pause = 1'b0;
        chk("t6_pause_busy", busy_cnt, 4);
        probe("t6_pause_hold", 17, 15, 1, 0, 0, 0, 0);

        // Exact-multiple steps line sprite1 up for a simultaneous x/y bounce at (0,352)
        repeat (3) frame(1);
        repeat (275) frame(4);
        chk("corner_count", corner_cnt, 1);
        probe("corner_s1", 0, 352, 1, 1, 0, 0, 7);

        repeat (30) frame(7);
        repeat (30) frame(3);
        repeat (3) frame(0);
        frame(5, 1);
        repeat (20) frame(5);
        frame(6, 1);

        @(negedge clk);
        speed = 3'd4;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        probe("midrst_s0", 16, 16, 1, 0, 0, 0, 0);
        probe("midrst_s3", 300, 200, 1, 3, 92, 88, 3);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
